ps2_mouse_cursor: RTL and testbench



---
 rtl/ps2_mouse_cursor.sv | 167 ++++++++++++++++
 tb/tb_ps2_mouse_cursor.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_mouse_cursor.sv
// PS/2 mouse receiver: 11-bit frames into 3-byte stream packets.
// Outputs a clamped cursor position, a coarse grid cell and button states.
module ps2_mouse_cursor #(
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int X_MAX          = 639,
  parameter int Y_MAX          = 479,
  parameter int X_INIT         = 320,
  parameter int Y_INIT         = 240
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [9:0] cursor_x,
  output logic [9:0] cursor_y,
  output logic [3:0] grid_x,
  output logic [3:0] grid_y,
  output logic       btn_left,
  output logic       btn_right,
  output logic       pkt_valid,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic signed [11:0] XM = 12'(X_MAX);
  localparam logic signed [11:0] YM = 12'(Y_MAX);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  state_t          state;
  logic [2:0]      ck_q;
  logic [1:0]      dt_q;
  logic [2:0]      bcnt;
  logic [7:0]      sr;
  logic            par_ok;
  logic [1:0]      idx;
  logic [7:0]      b0;
  logic [7:0]      b1;
  logic [TW-1:0]   to_cnt;
  logic            fall;
  logic            bit_in;
  logic            timeout;
  logic signed [11:0] dx;
  logic signed [11:0] dy;
  logic signed [11:0] nx;
  logic signed [11:0] ny;
  logic [9:0]      nx_c;
  logic [9:0]      ny_c;

  assign fall    = ck_q[2] & ~ck_q[1];
  assign bit_in  = dt_q[1];
  assign timeout = (state != S_IDLE) && !fall &&
                   (to_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign grid_x  = cursor_x[9:6];
  assign grid_y  = cursor_y[8:5];

  // The third byte is still in sr when the packet is applied.
  always_comb begin
    dx = b0[6] ? 12'sd0 : {{4{b0[4]}}, b1};
    dy = b0[7] ? 12'sd0 : {{4{b0[5]}}, sr};
    nx = $signed({2'b00, cursor_x}) + dx;
    ny = $signed({2'b00, cursor_y}) - dy;
    if (nx[11])
      nx_c = '0;
    else if (nx > XM)
      nx_c = 10'(X_MAX);
    else
      nx_c = nx[9:0];
    if (ny[11])
      ny_c = '0;
    else if (ny > YM)
      ny_c = 10'(Y_MAX);
    else
      ny_c = ny[9:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ck_q      <= '1;
      dt_q      <= '1;
      state     <= S_IDLE;
      bcnt      <= '0;
      sr        <= '0;
      par_ok    <= 1'b0;
      idx       <= '0;
      b0        <= '0;
      b1        <= '0;
      to_cnt    <= '0;
      cursor_x  <= 10'(X_INIT);
      cursor_y  <= 10'(Y_INIT);
      btn_left  <= 1'b0;
      btn_right <= 1'b0;
      pkt_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      ck_q      <= {ck_q[1:0], ps2_clk};
      dt_q      <= {dt_q[0], ps2_data};
      pkt_valid <= 1'b0;
      frame_err <= 1'b0;

      if (fall || state == S_IDLE)
        to_cnt <= '0;
      else
        to_cnt <= to_cnt + 1'b1;

      if (timeout) begin
        state     <= S_IDLE;
        idx       <= '0;
        frame_err <= 1'b1;
      end else if (fall) begin
        unique case (state)
          S_IDLE: begin
            if (!bit_in) begin
              state <= S_DATA;
              bcnt  <= '0;
            end
          end
          S_DATA: begin
            sr   <= {bit_in, sr[7:1]};
            bcnt <= bcnt + 1'b1;
            if (bcnt == 3'd7)
              state <= S_PAR;
          end
          S_PAR: begin
            par_ok <= ^{sr, bit_in};
            state  <= S_STOP;
          end
          S_STOP: begin
            state <= S_IDLE;
            if (bit_in && par_ok) begin
              unique case (1'b1)
                (idx == 2'd0): begin
                  if (sr[3]) begin
                    b0  <= sr;
                    idx <= 2'd1;
                  end
                end
                (idx == 2'd1): begin
                  b1  <= sr;
                  idx <= 2'd2;
                end
                default: begin
                  idx       <= '0;
                  pkt_valid <= 1'b1;
                  btn_left  <= b0[0];
                  btn_right <= b0[1];
                  cursor_x  <= nx_c;
                  cursor_y  <= ny_c;
                end
              endcase
            end else begin
              frame_err <= 1'b1;
              idx       <= '0;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_mouse_cursor.sv
// Bench for ps2_mouse_cursor: directed and random packets
// checked against an arithmetic cursor model.
module tb_ps2_mouse_cursor;

  localparam int H = 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ps2_clk;
  logic       ps2_data;
  logic [9:0] cursor_x;
  logic [9:0] cursor_y;
  logic [3:0] grid_x;
  logic [3:0] grid_y;
  logic       btn_left;
  logic       btn_right;
  logic       pkt_valid;
  logic       frame_err;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int pv_cnt = 0;
  int fe_cnt = 0;
  int fe_cyc = 0;
  int last_fall = 0;
  int mx, my, mbl, mbr;

  ps2_mouse_cursor dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .cursor_x  (cursor_x),
    .cursor_y  (cursor_y),
    .grid_x    (grid_x),
    .grid_y    (grid_y),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .pkt_valid (pkt_valid),
    .frame_err (frame_err)
  );

  always #20 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp)
      n_pass++;
    else
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (pkt_valid)
        pv_cnt++;
      if (frame_err) begin
        fe_cnt++;
        fe_cyc = cyc;
      end
      if (pkt_valid || frame_err)
        chk("excl", int'(pkt_valid & frame_err), 0);
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    wait_clk(H);
    ps2_clk   = 1'b0;
    last_fall = cyc;
    wait_clk(H);
    ps2_clk = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad = 0);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++)
      ps2_bit(b[i]);
    ps2_bit(~^b ^ bad);
    ps2_bit(1'b1);
    wait_clk(H);
  endtask

  function automatic int clamp(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic model_pkt(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2);
    int dx, dy;
    dx = b0[4] ? int'(b1) - 256 : int'(b1);
    dy = b0[5] ? int'(b2) - 256 : int'(b2);
    if (b0[6]) dx = 0;
    if (b0[7]) dy = 0;
    mx  = clamp(mx + dx, 639);
    my  = clamp(my - dy, 479);
    mbl = b0[0];
    mbr = b0[1];
  endtask

  task automatic model_reset();
    mx = 320; my = 240; mbl = 0; mbr = 0;
  endtask

  task automatic check_state();
    chk("cursor_x", cursor_x, mx);
    chk("cursor_y", cursor_y, my);
    chk("grid_x", grid_x, mx / 64);
    chk("grid_y", grid_y, my / 32);
    chk("btn_left", btn_left, mbl);
    chk("btn_right", btn_right, mbr);
  endtask

  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2);
    int pv0, fe0;
    pv0 = pv_cnt;
    fe0 = fe_cnt;
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
    wait_clk(4);
    model_pkt(b0, b1, b2);
    chk("pkt_pulse", pv_cnt - pv0, 1);
    chk("no_err", fe_cnt - fe0, 0);
    check_state();
  endtask

  task automatic check_reset_outs();
    chk("rst_x", cursor_x, 320);
    chk("rst_y", cursor_y, 240);
    chk("rst_bl", btn_left, 0);
    chk("rst_br", btn_right, 0);
    chk("rst_pv", pkt_valid, 0);
    chk("rst_fe", frame_err, 0);
  endtask

  initial begin
    int pv0, fe0;
    logic [7:0] r0, r1, r2;
    rst_n    = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    model_reset();
    wait_clk(5);
    check_reset_outs();
    rst_n = 1'b1;
    wait_clk(5);

    send_pkt(8'h09, 8'h0A, 8'h00);
    send_pkt(8'h28, 8'h00, 8'hF6);
    for (int i = 0; i < 3; i++)
      send_pkt(8'h18, 8'h80, 8'h00);
    send_pkt(8'h4A, 8'h7F, 8'h00);

    // Bad parity on the X byte aborts the packet.
    pv0 = pv_cnt;
    fe0 = fe_cnt;
    send_byte(8'h08);
    send_byte(8'h05, 1);
    send_byte(8'h00);
    wait_clk(4);
    chk("par_err", fe_cnt - fe0, 1);
    chk("par_nopkt", pv_cnt - pv0, 0);
    send_pkt(8'h08, 8'h05, 8'h00);

    // A byte without bit3 at packet start is dropped silently.
    pv0 = pv_cnt;
    fe0 = fe_cnt;
    send_byte(8'h00);
    wait_clk(4);
    chk("stray_err", fe_cnt - fe0, 0);
    chk("stray_pkt", pv_cnt - pv0, 0);
    send_pkt(8'h08, 8'h01, 8'h01);

    // Partial frame followed by a long idle clock.
    pv0 = pv_cnt;
    fe0 = fe_cnt;
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++)
      ps2_bit(1'b1);
    wait_clk(6000);
    chk("to_err", fe_cnt - fe0, 1);
    chk("to_lat", int'((fe_cyc - last_fall) >= 4995 &&
                       (fe_cyc - last_fall) <= 5010), 1);
    chk("to_nopkt", pv_cnt - pv0, 0);
    send_pkt(8'h09, 8'h03, 8'hFD);

    for (int i = 0; i < 25; i++) begin
      r0 = 8'($urandom);
      r0[3] = 1'b1;
      if ($urandom_range(0, 5) != 0)
        r0[7:6] = 2'b00;
      r1 = 8'($urandom);
      r2 = 8'($urandom);
      send_pkt(r0, r1, r2);
    end

    // Reset in the middle of the third byte.
    send_byte(8'h08);
    send_byte(8'h10);
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++)
      ps2_bit(1'b1);
    rst_n = 1'b0;
    wait_clk(3);
    model_reset();
    check_reset_outs();
    chk("rst_gx", grid_x, 5);
    chk("rst_gy", grid_y, 7);
    ps2_data = 1'b1;
    rst_n = 1'b1;
    wait_clk(5);
    send_pkt(8'h19, 8'hF0, 8'h20);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
